// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types and size codes for the memory port arbiter
package arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_ADDR = 2'd1,
    ARB_WAIT = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } arb_owner_e;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

endpackage

// File: rtl/arb_grant_select.sv
// rtl/arb_grant_select.sv - combinational pick between IF and MEM requests
// ARB_ROUND_ROBIN_EN: on a tie, grant whichever requester did not own the last grant.
module arb_grant_select
  import arb_pkg::*;
(
`ifdef ARB_ROUND_ROBIN_EN
  input  logic i_last_owner,
`endif
  input  logic i_inst_pend,
  input  logic i_data_pend,
  output logic o_grant_valid,
  output logic o_grant_owner
);

  always_comb begin
    o_grant_valid = i_inst_pend | i_data_pend;
    o_grant_owner = OWN_INST;
    if (i_inst_pend && i_data_pend) begin
`ifdef ARB_ROUND_ROBIN_EN
      o_grant_owner = (i_last_owner == OWN_INST) ? OWN_DATA : OWN_INST;
`else
      o_grant_owner = OWN_DATA;
`endif
    end else if (i_data_pend) begin
      o_grant_owner = OWN_DATA;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - one-outstanding arbiter sharing the SRAM-style port between IF and MEM
// ARB_ROUND_ROBIN_EN selects round-robin tie-breaking; default build gives data fixed priority.
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,

  input  logic              inst_req_i,
  input  logic [ADDR_W-1:0] inst_addr_i,
  output logic [DATA_W-1:0] inst_rdata_o,
  output logic              inst_data_ok_o,

  input  logic              data_req_i,
  input  logic              data_wr_i,
  input  logic [1:0]        data_size_i,
  input  logic [ADDR_W-1:0] data_addr_i,
  input  logic [DATA_W-1:0] data_wdata_i,
  output logic [DATA_W-1:0] data_rdata_o,
  output logic              data_data_ok_o,

  output logic              mem_req_o,
  output logic              mem_wr_o,
  output logic [1:0]        mem_size_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_addr_ok_i,
  input  logic              mem_data_ok_i,
  input  logic [DATA_W-1:0] mem_rdata_i,

  output logic              stall_req_o
);

  localparam logic [1:0] ST_IDLE = ARB_IDLE;
  localparam logic [1:0] ST_ADDR = ARB_ADDR;
  localparam logic [1:0] ST_WAIT = ARB_WAIT;

  logic [1:0]        r_state;
  logic              r_owner;
  logic              r_kill;
  logic              r_mem_wr;
  logic [1:0]        r_mem_size;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
`ifdef ARB_ROUND_ROBIN_EN
  logic              r_last_owner;
`endif

  logic w_inst_pend;
  logic w_data_pend;
  logic w_grant_valid;
  logic w_grant_owner;
  logic w_in_txn;
  logic w_kill;
  logic w_resp;

  // A flush in IDLE means the fetch on inst_req_i is already stale.
  assign w_inst_pend = inst_req_i & ~flush_i;
  assign w_data_pend = data_req_i;

  arb_grant_select u_grant_select (
`ifdef ARB_ROUND_ROBIN_EN
    .i_last_owner  (r_last_owner),
`endif
    .i_inst_pend   (w_inst_pend),
    .i_data_pend   (w_data_pend),
    .o_grant_valid (w_grant_valid),
    .o_grant_owner (w_grant_owner)
  );

  assign w_in_txn = (r_state == ST_ADDR) || (r_state == ST_WAIT);
  // Live flush term lets a same-cycle flush suppress the returning pulse.
  assign w_kill   = r_kill | (flush_i & w_in_txn & (r_owner == OWN_INST));
  assign w_resp   = mem_data_ok_i & (r_state == ST_WAIT);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_owner <= OWN_INST;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_grant_valid) begin
            r_state <= ST_ADDR;
            r_owner <= w_grant_owner;
          end
        end
        ST_ADDR: begin
          if (mem_addr_ok_i) begin
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (mem_data_ok_i) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_mem_wr    <= 1'b0;
      r_mem_size  <= 2'd0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else if ((r_state == ST_IDLE) && w_grant_valid) begin
      if (w_grant_owner == OWN_DATA) begin
        r_mem_wr    <= data_wr_i;
        r_mem_size  <= data_size_i;
        r_mem_addr  <= data_addr_i;
        r_mem_wdata <= data_wdata_i;
      end else begin
        r_mem_wr    <= 1'b0;
        r_mem_size  <= SZ_WORD;
        r_mem_addr  <= inst_addr_i;
        r_mem_wdata <= '0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_kill <= 1'b0;
    end else if (w_resp) begin
      r_kill <= 1'b0;
    end else if (w_kill) begin
      r_kill <= 1'b1;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_last_owner <= OWN_INST;
    end else if ((r_state == ST_IDLE) && w_grant_valid) begin
      r_last_owner <= w_grant_owner;
    end
  end
`endif

  assign mem_req_o   = (r_state == ST_ADDR);
  assign mem_wr_o    = r_mem_wr;
  assign mem_size_o  = r_mem_size;
  assign mem_addr_o  = r_mem_addr;
  assign mem_wdata_o = r_mem_wdata;

  assign inst_rdata_o   = mem_rdata_i;
  assign data_rdata_o   = mem_rdata_i;
  assign inst_data_ok_o = w_resp & (r_owner == OWN_INST) & ~w_kill;
  assign data_data_ok_o = w_resp & (r_owner == OWN_DATA);

  assign stall_req_o = (inst_req_i & ~inst_data_ok_o) | (data_req_i & ~data_data_ok_o);

endmodule
